// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad column scanner with debounce and valid/ack
//            key-event delivery.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       clear_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [1:0]       col_q;
  logic [11:0]      samp_q;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             overrun_q, overrun_d;

  logic             sample, scan_done, emit;
  logic [15:0]      hits;
  logic [1:0]       n_hits;
  logic [3:0]       hit_code;
  logic             res_none, res_single;

  assign sample    = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign scan_done = sample && (col_q == 2'd3);

  // Column and row synchronizer, dwell counter, per-column row samples.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      div_cnt_q <= '0;
      col_q     <= 2'd0;
      samp_q    <= '0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      if (sample) begin
        div_cnt_q <= '0;
        col_q     <= col_q + 2'd1;
        case (col_q)
          2'd0:    samp_q[3:0]  <= ~row_s2_q;
          2'd1:    samp_q[7:4]  <= ~row_s2_q;
          2'd2:    samp_q[11:8] <= ~row_s2_q;
          default: ;
        endcase
      end else begin
        div_cnt_q <= div_cnt_q + CNT_W'(1);
      end
    end
  end

  // Column 3 is folded in live on the scan_done cycle; hits index = col*4+row.
  assign hits = {~row_s2_q, samp_q};

  always_comb begin
    n_hits   = 2'd0;
    hit_code = 4'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (hits[c*4 + r]) begin
          if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
          hit_code = 4'(r*4 + c);
        end
      end
    end
  end

  assign res_none   = (n_hits == 2'd0);
  assign res_single = (n_hits == 2'd1);

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    db_cnt_d = db_cnt_q;
    emit     = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (res_single) begin
            cand_d = hit_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d  = ST_HELD;
              db_cnt_d = '0;
              emit     = 1'b1;
            end else begin
              state_d  = ST_PRESS_DB;
              db_cnt_d = DB_W'(1);
            end
          end
        end
        ST_PRESS_DB: begin
          if (res_single && (hit_code == cand_q)) begin
            if (db_cnt_q + DB_W'(1) == DB_W'(DEBOUNCE_SCANS)) begin
              state_d  = ST_HELD;
              db_cnt_d = '0;
              emit     = 1'b1;
            end else begin
              db_cnt_d = db_cnt_q + DB_W'(1);
            end
          end else if (res_single) begin
            cand_d   = hit_code;
            db_cnt_d = DB_W'(1);
          end else begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
          end
        end
        ST_HELD: begin
          if (res_none || (res_single && (hit_code != cand_q))) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d  = ST_IDLE;
              db_cnt_d = '0;
            end else begin
              state_d  = ST_REL_DB;
              db_cnt_d = DB_W'(1);
            end
          end
        end
        default: begin // ST_REL_DB
          if (res_none || (res_single && (hit_code != cand_q))) begin
            if (db_cnt_q + DB_W'(1) == DB_W'(DEBOUNCE_SCANS)) begin
              state_d  = ST_IDLE;
              db_cnt_d = '0;
            end else begin
              db_cnt_d = db_cnt_q + DB_W'(1);
            end
          end else begin
            state_d  = ST_HELD;
            db_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // An ack coinciding with a new event frees the slot, so the event is kept.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (emit) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
    end
    key_down_d = (state_d == ST_HELD) || (state_d == ST_REL_DB);
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner (16-cycle scans).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN           = 4 * SCAN_DIV;

  logic        CLK = 1'b0;
  logic        clear_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        key_down;
  logic        overrun;

  logic [15:0] pressed;      // bit index = row*4 + col
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ev_cnt   = 0;
  logic        valid_prev = 1'b0;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .CLK      (CLK),
    .clear_n  (clear_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_down (key_down),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  // Passive keypad: a closed switch pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge CLK) begin
    if (clear_n && key_valid && !valid_prev) ev_cnt = ev_cnt + 1;
    valid_prev = key_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    pressed = 16'h0;
    key_ack = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    clear_n = 1'b1;
  endtask

  int ev0;

  initial begin
    clear_n = 1'b0;
    pressed = 16'h0;
    key_ack = 1'b0;

    // 1: reset values and column rotation
    do_reset();
    #1;
    check("rst_col", col_out, 4'b1110);
    check("rst_code", key_code, 4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    tick(3);  check("col_e3", col_out, 4'b1110);
    tick(1);  check("col_e4", col_out, 4'b1101);
    tick(4);  check("col_e8", col_out, 4'b1011);
    tick(4);  check("col_e12", col_out, 4'b0111);
    tick(4);  check("col_e16", col_out, 4'b1110);

    // 2: stable press of row2/col1 -> event on 2nd scan_done
    do_reset();
    ev0 = ev_cnt;
    pressed = 16'h0200;
    tick(2*SCAN - 1);
    check("k9_before", key_valid, 1'b0);
    tick(1);
    check("k9_valid", key_valid, 1'b1);
    check("k9_code", key_code, 4'd9);
    check("k9_down", key_down, 1'b1);
    tick(3*SCAN);
    check("k9_events", ev_cnt - ev0, 1);
    check("k9_ovr", overrun, 1'b0);

    // 3: press toggled every scan never qualifies
    do_reset();
    ev0 = ev_cnt;
    for (int s = 0; s < 6; s++) begin
      pressed = (s % 2 == 0) ? 16'h0200 : 16'h0000;
      tick(SCAN);
    end
    check("bounce_valid", key_valid, 1'b0);
    check("bounce_down", key_down, 1'b0);
    check("bounce_events", ev_cnt - ev0, 0);

    // 4: two keys together is MULTI
    do_reset();
    ev0 = ev_cnt;
    pressed = 16'h8001;
    tick(4*SCAN);
    check("multi_valid", key_valid, 1'b0);
    check("multi_down", key_down, 1'b0);
    check("multi_events", ev_cnt - ev0, 0);

    // 5: second event without ack sets overrun; ack then clears valid
    do_reset();
    pressed = 16'h0020;
    tick(3*SCAN);
    check("k5_valid", key_valid, 1'b1);
    check("k5_code", key_code, 4'd5);
    pressed = 16'h0000;
    tick(3*SCAN);
    check("k5_released", key_down, 1'b0);
    check("k5_ovr_pre", overrun, 1'b0);
    pressed = 16'h0400;
    tick(3*SCAN);
    check("ovr_code", key_code, 4'd5);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_down", key_down, 1'b1);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    check("ack_valid", key_valid, 1'b0);
    check("ack_ovr", overrun, 1'b1);
    tick(2);
    check("ack_idle_valid", key_valid, 1'b0);

    // 6: asynchronous reset while HELD with a pending event
    do_reset();
    pressed = 16'h0200;
    tick(41);
    check("ar_pre_valid", key_valid, 1'b1);
    check("ar_pre_col", col_out, 4'b1011);
    #2;
    clear_n = 1'b0;
    #1;
    check("ar_valid", key_valid, 1'b0);
    check("ar_down", key_down, 1'b0);
    check("ar_col", col_out, 4'b1110);
    check("ar_code", key_code, 4'd0);
    pressed = 16'h0;
    tick(2);
    clear_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
